// File: rtl/alu_op_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU command sequencer:
//   - alu_op_e : 3-bit ALU opcode encodings
//   - state_e  : sequencer FSM states
//   - CMD_CTRL_BITS : non-operand bits per queued command (op + chain + last)
// ----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_NOT  = 3'b011,
        OP_SUB  = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_NAND = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int CMD_CTRL_BITS = 5;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
// Show-ahead synchronous FIFO holding queued ALU commands.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the queue)
//   push, push_data : write request and data; ignored while full
//   pop,  pop_data  : read request and head entry; ignored while empty
//   full, empty     : occupancy flags
// ----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DATA_W = 69,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full queue is refused even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Queues ALU commands and issues them one at a time onto an external ALU.
// Each result lands in an accumulator that later commands may chain from;
// commands flagged 'last' return the accumulator over a valid/ready port.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_op/a/b/chain/last       : command fields
//   alu_lhs/alu_rhs/alu_opp     : registered operands/opcode to the ALU
//   alu_res                     : combinational ALU result
//   res_valid/res_ready/res_data: result handshake (res_data = accumulator)
//   busy                        : FSM active or queue non-empty
//   ops_done                    : executed command count (wraps)
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    input  logic             cmd_last,
    output logic [WIDTH-1:0] alu_lhs,
    output logic [WIDTH-1:0] alu_rhs,
    output logic [2:0]       alu_opp,
    input  logic [WIDTH-1:0] alu_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [15:0]      ops_done
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             chain;
        logic             last;
    } cmd_t;

    localparam int CMD_W = CMD_CTRL_BITS + 2 * WIDTH;
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_e           state;
    state_e           state_next;
    cmd_t             cmd_in;
    cmd_t             head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] exec_cnt;
    logic             exec_done;
    logic             cur_last;
    logic [WIDTH-1:0] acc;
    logic             acc_valid;

    assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain, last: cmd_last};
    assign fifo_push = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign exec_done = (state == S_EXEC) && (exec_cnt == EXEC_LAST);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_next = cur_last ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_lhs   <= '0;
            alu_rhs   <= '0;
            alu_opp   <= '0;
            exec_cnt  <= '0;
            cur_last  <= 1'b0;
            acc       <= '0;
            acc_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (fifo_pop) begin
                // Chaining before any result exists since reset reads as zero.
                alu_lhs  <= head.chain ? (acc_valid ? acc : '0) : head.a;
                alu_rhs  <= head.b;
                alu_opp  <= head.op;
                cur_last <= head.last;
                exec_cnt <= '0;
            end else if ((state == S_EXEC) && !exec_done) begin
                exec_cnt <= exec_cnt + 1'b1;
            end

            if (exec_done) begin
                acc       <= alu_res;
                acc_valid <= 1'b1;
                ops_done  <= ops_done + 1'b1;
            end
        end
    end

    assign cmd_ready = !fifo_full;
    assign res_valid = (state == S_RESP);
    assign res_data  = acc;
    assign busy      = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Drives directed and random command streams into alu_op_sequencer with a
// behavioural ALU on its operand ports. A transaction-level model (command
// queue, one in-flight command with a remaining-cycle count, pending response)
// predicts every output each cycle; directed cases also pin literal results.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int WIDTH       = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int EXEC_CYCLES = 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;
    logic             cmd_last;
    logic [WIDTH-1:0] alu_lhs;
    logic [WIDTH-1:0] alu_rhs;
    logic [2:0]       alu_opp;
    logic [WIDTH-1:0] alu_res;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic [15:0]      ops_done;

    int n_checks = 0;
    int n_pass   = 0;

    alu_op_sequencer #(
        .WIDTH       (WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .EXEC_CYCLES (EXEC_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .cmd_last  (cmd_last),
        .alu_lhs   (alu_lhs),
        .alu_rhs   (alu_rhs),
        .alu_opp   (alu_opp),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU standing in for the external datapath.
    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_NOT:  return ~a;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return ~(a & b);
        endcase
    endfunction

    assign alu_res = alu_f(alu_opp, alu_lhs, alu_rhs);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               chain;
        bit               last;
    } mcmd_t;

    mcmd_t            mq[$];
    mcmd_t            m_cur;
    mcmd_t            m_new;
    bit               m_have_cur;
    bit               m_resp;
    bit               m_push_ok;
    int               m_left;
    logic [WIDTH-1:0] m_acc;
    bit               m_acc_valid;
    logic [15:0]      m_ops;
    logic [WIDTH-1:0] m_lhs;
    logic [WIDTH-1:0] m_rhs;
    logic [2:0]       m_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_have_cur  = 0;
            m_resp      = 0;
            m_left      = 0;
            m_acc       = '0;
            m_acc_valid = 0;
            m_ops       = '0;
            m_lhs       = '0;
            m_rhs       = '0;
            m_op        = '0;
        end else begin
            m_push_ok = cmd_valid && (mq.size() < FIFO_DEPTH);
            m_new = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain, last: cmd_last};
            if (m_resp) begin
                if (res_ready) m_resp = 0;
            end else if (m_have_cur) begin
                m_left--;
                if (m_left == 0) begin
                    m_acc       = alu_f(m_op, m_lhs, m_rhs);
                    m_acc_valid = 1;
                    m_ops       = m_ops + 16'd1;
                    m_have_cur  = 0;
                    m_resp      = m_cur.last;
                end
            end else if (mq.size() > 0) begin
                m_cur      = mq.pop_front();
                m_lhs      = m_cur.chain ? (m_acc_valid ? m_acc : '0) : m_cur.a;
                m_rhs      = m_cur.b;
                m_op       = m_cur.op;
                m_have_cur = 1;
                m_left     = EXEC_CYCLES;
            end
            if (m_push_ok) mq.push_back(m_new);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < FIFO_DEPTH));
        check("res_valid", 32'(res_valid), 32'(m_resp));
        check("res_data",  res_data, m_acc);
        check("busy",      32'(busy), 32'(m_have_cur || m_resp || (mq.size() > 0)));
        check("ops_done",  32'(ops_done), 32'(m_ops));
        check("alu_lhs",   alu_lhs, m_lhs);
        check("alu_rhs",   alu_rhs, m_rhs);
        check("alu_opp",   32'(alu_opp), 32'(m_op));
    end

    // ---------------- stimulus helpers (start and end on a falling edge) ----------------
    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  res_data, 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_ops_done"},  32'(ops_done), 32'd0);
        check({tag, "_alu_lhs"},   alu_lhs, 32'd0);
        check({tag, "_alu_rhs"},   alu_rhs, 32'd0);
        check({tag, "_alu_opp"},   32'(alu_opp), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic chain, input logic last);
        int t;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        cmd_last  = last;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({name, "_arrived"}, 32'(res_valid), 32'd1);
    endtask

    task automatic take_result(input string name, input logic [31:0] exp);
        wait_valid(name);
        check(name, res_data, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int t;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_chain = 1'b0;
        cmd_last  = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        do_reset("rst0");

        // SLT -> ADD chain: slt(-5, 10) = 1, then 1 + 100 = 101.
        push(OP_SLT, 32'hFFFF_FFFB, 32'd10, 1'b0, 1'b0);
        push(OP_ADD, 32'h0, 32'd100, 1'b1, 1'b1);
        take_result("slt_add", 32'h0000_0065);
        check("slt_add_ops", 32'(ops_done), 32'd2);
        repeat (6) @(negedge clk);
        check("slt_add_single_pulse", 32'(res_valid), 32'd0);

        // NOT -> SUB chain.
        push(OP_NOT, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
        push(OP_SUB, 32'h0, 32'h0000_0F0F, 1'b1, 1'b1);
        take_result("not_sub", 32'h0000_F0F0);

        // SUB -> NAND chain.
        push(OP_SUB, 32'd100, 32'd25, 1'b0, 1'b0);
        push(OP_NAND, 32'h0, 32'd75, 1'b1, 1'b1);
        take_result("sub_nand", 32'hFFFF_FFB4);

        // Backpressure: result held while the queue fills behind it.
        push(OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b1);
        wait_valid("bp_xor");
        check("bp_xor", res_data, 32'hEDCB_5678);
        push(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
        check("bp_ready1", 32'(cmd_ready), 32'd1);
        push(OP_ADD, 32'h0, 32'd10, 1'b1, 1'b0);
        check("bp_ready2", 32'(cmd_ready), 32'd1);
        push(OP_XOR, 32'h0, 32'h0000_00FF, 1'b1, 1'b0);
        check("bp_ready3", 32'(cmd_ready), 32'd1);
        push(OP_SUB, 32'h0, 32'd2, 1'b1, 1'b1);
        check("bp_ready4_full", 32'(cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("bp_hold_valid", 32'(res_valid), 32'd1);
        check("bp_hold_data", res_data, 32'hEDCB_5678);
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_xor_taken", 32'(res_valid), 32'd0);
        // ((1+2)+10) ^ 0xFF = 0xF2, minus 2 = 0xF0: only correct if drained in order.
        wait_valid("bp_drain");
        check("bp_drain_data", res_data, 32'h0000_00F0);
        check("bp_drain_ops", 32'(ops_done), 32'd11);
        @(negedge clk);
        res_ready = 1'b0;

        // Chain from reset, with accept-to-result latency.
        do_reset("rst1");
        push(OP_SUB, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b1);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(1 + EXEC_CYCLES));
        check("chain_rst_lhs", alu_lhs, 32'h0);
        take_result("chain_rst", 32'hFFFF_FFFF);

        // Reset in the middle of EXEC with commands queued behind.
        push(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b1);
        push(OP_ADD, 32'd7, 32'd8, 1'b0, 1'b1);
        push(OP_ADD, 32'd9, 32'd1, 1'b0, 1'b1);
        check("mid_exec_busy", 32'(busy), 32'd1);
        check("mid_exec_no_result", 32'(res_valid), 32'd0);
        do_reset("rst_mid");
        check("after_rst_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("after_rst_no_valid", 32'(res_valid), 32'd0);
        check("after_rst_ops", 32'(ops_done), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = $urandom;
            cmd_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            cmd_chain = ($urandom_range(0, 1) == 1);
            cmd_last  = ($urandom_range(0, 2) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
